// File: rtl/spi_acl_responder_pkg.sv
// Shared constants and types for the ADXL362-style SPI register responder.
package spi_acl_responder_pkg;

    // SPI command bytes understood by the responder.
    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    // Fixed register map (6-bit register addresses).
    localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
    localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
    localparam logic [5:0] ADDR_PART_ID   = 6'h02;
    localparam logic [5:0] ADDR_XDATA     = 6'h08;
    localparam logic [5:0] ADDR_YDATA     = 6'h09;
    localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
    localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
    localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
    localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
    localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
    localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
    localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;

    // Transaction phases of the responder.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_SKIP = 3'd4
    } acl_state_t;

    // High byte of a 12-bit signed sample: sign-extended bits [11:8].
    function automatic logic [7:0] sample_hi(input logic [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, with level and
// single-cycle rise/fall pulses in the system clock domain.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the asynchronous input through the synchronizer and keep the
    // previous synchronized value for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop capture its
        // neighbour's pre-edge value, which is what makes this a shift chain.
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_acl_responder.sv
// SPI mode-0 slave emulating the ADXL362 register interface: IDs, live
// X/Y/Z samples (snapshotted per transaction) and a bank of config registers.
module spi_acl_responder
    import spi_acl_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_AD    = 8'hAD,
    parameter logic [7:0] DEVID_MST   = 8'h1D,
    parameter logic [7:0] PART_ID     = 8'hF2,
    parameter logic [5:0] CFG_BASE    = 6'h1F,
    parameter int         NUM_CFG     = 16
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [11:0] x_data,
    input  logic [11:0] y_data,
    input  logic [11:0] z_data,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic [15:0] txn_count
);

    localparam int CFG_IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    acl_state_t state, next_state;

    logic                 cs_armed;
    logic                 is_write;
    logic                 load_pending;
    logic [2:0]           bit_cnt;
    logic [6:0]           rx_shift;
    logic [7:0]           rx_byte;
    logic [6:0]           tx_shift;
    logic [7:0]           read_byte;
    logic [5:0]           addr_ptr;
    logic [5:0]           cfg_off;
    logic [CFG_IDX_W-1:0] cfg_idx;
    logic                 in_cfg;
    logic                 byte_done;
    logic                 txn_start;
    logic [11:0]          shadow_x, shadow_y, shadow_z;
    logic [7:0]           cfg_regs [NUM_CFG];

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(CLK100MHZ), .reset(reset), .async_in(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(CLK100MHZ), .reset(reset), .async_in(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(CLK100MHZ), .reset(reset), .async_in(mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only edges of cs_n and sclk, and the level of mosi, drive the protocol.
    assign unused_sync = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

    // The completed byte includes the bit being sampled on this sclk rise.
    assign rx_byte   = {rx_shift, mosi_level};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != ST_IDLE);
    // A transaction only starts once cs_n has been seen high since reset.
    assign txn_start = cs_fall && cs_armed && (state == ST_IDLE);

    assign cfg_off = addr_ptr - CFG_BASE;
    assign cfg_idx = cfg_off[CFG_IDX_W-1:0];
    assign in_cfg  = (addr_ptr >= CFG_BASE) && ({1'b0, cfg_off} < 7'(NUM_CFG));

    // State register.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic: phase advances per completed byte, cs_n rise aborts.
    always_comb begin
        // NOTE: next_state gets a default before any branch, so every path
        // assigns it and no latch is inferred.
        next_state = state;
        if (cs_rise) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (txn_start) next_state = ST_CMD;
                ST_CMD:  if (byte_done) begin
                    if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) next_state = ST_ADDR;
                    else                                             next_state = ST_SKIP;
                end
                ST_ADDR: if (byte_done) next_state = ST_DATA;
                default: next_state = state;
            endcase
        end
    end

    // Read map: config range first, then fixed IDs and sample bytes.
    always_comb begin
        read_byte = 8'h00;
        if (in_cfg) begin
            read_byte = cfg_regs[cfg_idx];
        end else begin
            case (addr_ptr)
                ADDR_DEVID_AD:  read_byte = DEVID_AD;
                ADDR_DEVID_MST: read_byte = DEVID_MST;
                ADDR_PART_ID:   read_byte = PART_ID;
                ADDR_XDATA:     read_byte = shadow_x[11:4];
                ADDR_YDATA:     read_byte = shadow_y[11:4];
                ADDR_ZDATA:     read_byte = shadow_z[11:4];
                ADDR_XDATA_L:   read_byte = shadow_x[7:0];
                ADDR_XDATA_H:   read_byte = sample_hi(shadow_x);
                ADDR_YDATA_L:   read_byte = shadow_y[7:0];
                ADDR_YDATA_H:   read_byte = sample_hi(shadow_y);
                ADDR_ZDATA_L:   read_byte = shadow_z[7:0];
                ADDR_ZDATA_H:   read_byte = sample_hi(shadow_z);
                default:        read_byte = 8'h00;
            endcase
        end
    end

    // Datapath: bit counting, shift registers, address pointer, config writes.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            cs_armed     <= 1'b0;
            is_write     <= 1'b0;
            load_pending <= 1'b0;
            bit_cnt      <= 3'd0;
            rx_shift     <= 7'd0;
            tx_shift     <= 7'd0;
            addr_ptr     <= 6'd0;
            shadow_x     <= 12'd0;
            shadow_y     <= 12'd0;
            shadow_z     <= 12'd0;
            miso         <= 1'b0;
            miso_oe      <= 1'b0;
            busy         <= 1'b0;
            wr_strobe    <= 1'b0;
            wr_addr      <= 6'd0;
            wr_data      <= 8'd0;
            txn_count    <= 16'd0;
            // NOTE: the config array is cleared in the reset branch because an
            // unwritten register must read back 0; this keeps it in flops.
            for (int i = 0; i < NUM_CFG; i++) cfg_regs[i] <= 8'h00;
        end else begin
            wr_strobe    <= 1'b0;
            load_pending <= 1'b0;
            if (cs_rise) begin
                cs_armed <= 1'b1;
                busy     <= 1'b0;
                miso_oe  <= 1'b0;
                miso     <= 1'b0;
                bit_cnt  <= 3'd0;
                tx_shift <= 7'd0;
                if (state != ST_IDLE) txn_count <= txn_count + 16'd1;
            end else if (txn_start) begin
                busy     <= 1'b1;
                miso_oe  <= 1'b1;
                miso     <= 1'b0;
                bit_cnt  <= 3'd0;
                is_write <= 1'b0;
                shadow_x <= x_data;
                shadow_y <= y_data;
                shadow_z <= z_data;
            end else if (state != ST_IDLE) begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        ST_CMD: is_write <= (rx_byte == CMD_WRITE);
                        ST_ADDR: begin
                            addr_ptr     <= rx_byte[5:0];
                            load_pending <= !is_write;
                        end
                        ST_DATA: begin
                            if (is_write && in_cfg) begin
                                cfg_regs[cfg_idx] <= rx_byte;
                                wr_strobe         <= 1'b1;
                                wr_addr           <= addr_ptr;
                                wr_data           <= rx_byte;
                            end
                            addr_ptr     <= addr_ptr + 6'd1;
                            load_pending <= !is_write;
                        end
                        default: ;
                    endcase
                end
                // The fall that closes a byte (bit_cnt wrapped to 0) must not
                // shift: the freshly loaded MSB has to survive to the next rise.
                if (load_pending) begin
                    miso     <= read_byte[7];
                    tx_shift <= read_byte[6:0];
                end else if (sclk_fall && bit_cnt != 3'd0 && state == ST_DATA && !is_write) begin
                    miso     <= tx_shift[6];
                    tx_shift <= {tx_shift[5:0], 1'b0};
                end
            end
        end
    end

endmodule
